// File: rtl/moore_rr_arbiter_pkg.sv
// Shared types and helpers for the Moore round-robin arbiter.
package moore_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/moore_rr_arbiter_if.sv
// Request/grant bundle between N requesters and the arbiter.
interface moore_rr_arbiter_if #(
    parameter int N = 4
);
    localparam int ID_W = $clog2(N);

    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic            busy;
    logic [ID_W-1:0] owner_id;
    logic            timeout;

    modport master (output req, input grant, busy, owner_id, timeout);
    modport slave  (input req, output grant, busy, owner_id, timeout);

endinterface

// File: rtl/moore_rr_arbiter_pick.sv
// Combinational round-robin pick: first set bit at or after ptr, wrapping mod N.
module rr_priority_pick #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);
    localparam logic [ID_W:0] NV = (ID_W+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [ID_W-1:0] off;
    logic [ID_W:0]   sum;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        found = 1'b0;
        off   = '0;
        // descending scan so the lowest rotated position wins
        for (int i = N-1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = ID_W'(i);
            end
        end
        sum = {1'b0, off} + {1'b0, ptr};
        if (sum >= NV) sum = sum - NV;
        idx = sum[ID_W-1:0];
    end

endmodule

// File: rtl/moore_rr_arbiter.sv
// Moore round-robin arbiter: registered grant with bounded hold and a turnaround gap.
module moore_rr_arbiter
    import moore_rr_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int GAP_CYC  = 1
) (
    input logic               clk,
    input logic               areset,
    moore_rr_arbiter_if.slave arb
);
    localparam int ID_W = $clog2(N);
    localparam int HW   = $clog2(MAX_HOLD + 1);
    localparam int GW   = $clog2(GAP_CYC + 1);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] rr_ptr, owner_q, pick_idx;
    logic [HW-1:0]   hold_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [N-1:0]    grant_q;
    logic            busy_q, timeout_q, pick_found;

    rr_priority_pick #(.N(N)) u_pick (
        .req   (arb.req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_found) state_d = ST_GRANT;
            ST_GRANT: if (!arb.req[owner_q] || hold_cnt == HW'(MAX_HOLD)) state_d = ST_GAP;
            ST_GAP:   if (gap_cnt == GW'(GAP_CYC)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            rr_ptr    <= '0;
            owner_q   <= '0;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (pick_found) begin
                    owner_q  <= pick_idx;
                    grant_q  <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    busy_q   <= 1'b1;
                    hold_cnt <= HW'(1);
                end
                ST_GRANT: if (state_d == ST_GAP) begin
                    grant_q   <= '0;
                    busy_q    <= 1'b0;
                    rr_ptr    <= ID_W'(wrap_inc(int'(owner_q), N));
                    gap_cnt   <= GW'(1);
                    // a still-requesting owner leaving GRANT can only mean hold expiry
                    timeout_q <= arb.req[owner_q];
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
                ST_GAP: if (state_d == ST_GAP) gap_cnt <= gap_cnt + GW'(1);
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign arb.grant    = grant_q;
    assign arb.busy     = busy_q;
    assign arb.owner_id = owner_q;
    assign arb.timeout  = timeout_q;

endmodule

// File: tb/tb_moore_rr_arbiter.sv
// Bench for moore_rr_arbiter: directed scenarios plus random traffic against a tenure-level model.
module tb_moore_rr_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 16;
    localparam int GAP_CYC  = 1;
    localparam int ID_W     = $clog2(N);
    localparam int VW       = N + ID_W + 2;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    moore_rr_arbiter_if #(.N(N)) bus ();

    moore_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .GAP_CYC(GAP_CYC)) dut (
        .clk    (clk),
        .areset (areset),
        .arb    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] obs;
    assign obs = {bus.grant, bus.busy, bus.owner_id, bus.timeout};

    // tenure model: cur = owner (-1 none), held = cycles granted, gap = turnaround cycles left
    int m_cur, m_held, m_gap, m_ptr, m_owner;
    logic m_to;

    task automatic model_reset();
        m_cur = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_owner = 0; m_to = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int i;
        m_to = 1'b0;
        if (m_cur >= 0) begin
            if (!r[m_cur[ID_W-1:0]] || m_held == MAX_HOLD) begin
                m_to  = r[m_cur[ID_W-1:0]];
                m_ptr = (m_cur + 1) % N;
                m_cur = -1;
                m_gap = GAP_CYC;
            end else m_held++;
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int o = 0; o < N; o++) begin
                i = (m_ptr + o) % N;
                if (m_cur < 0 && r[i[ID_W-1:0]]) begin
                    m_cur = i; m_owner = i; m_held = 1;
                end
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] g;
        g = '0;
        if (m_cur >= 0) g[m_cur[ID_W-1:0]] = 1'b1;
        return {g, m_cur >= 0, m_owner[ID_W-1:0], m_to};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(bus.req);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        bus.req = '0;
        @(posedge clk);
        #1;
        areset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1;
        if (obs !== '0) begin errors++; $display("FAIL reset_hold got %h exp 0", obs); end
        checks++;
        areset = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            tick();
            if (obs !== '0) begin errors++; $display("FAIL reset_idle cyc %0d got %h exp 0", c, obs); end
            checks++;
        end
    endtask

    task automatic test_voluntary();
        do_reset();
        bus.req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.grant !== 4'b0100 || obs !== exp_vec()) begin
                errors++; $display("FAIL vol_grant cyc %0d got %h exp %h", c, obs, exp_vec());
            end
            checks++;
        end
        bus.req = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (bus.grant !== '0 || bus.timeout !== 1'b0 || obs !== exp_vec()) begin
                errors++; $display("FAIL vol_gap cyc %0d got %h exp %h", c, obs, exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_ord [5];
        logic [N-1:0] ord [$];
        int gaps [$];
        int zeros, held;
        exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        bus.req = 4'b1111;
        zeros = 0; held = 0;
        for (int c = 0; c < 60 && ord.size() < 5; c++) begin
            tick();
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL rr_model cyc %0d got %h exp %h", c, obs, exp_vec());
            end
            checks++;
            if (bus.grant != '0) begin
                if (held == 0) begin
                    ord.push_back(bus.grant);
                    if (ord.size() > 1) gaps.push_back(zeros);
                end
                held++;
                zeros = 0;
                bus.req = (held == 2) ? (4'b1111 & ~bus.grant) : 4'b1111;
            end else begin
                held = 0;
                zeros++;
                bus.req = 4'b1111;
            end
        end
        if (ord.size() != 5) begin errors++; $display("FAIL rr_count got %0d exp 5", ord.size()); end
        checks++;
        for (int k = 0; k < ord.size(); k++) begin
            if (ord[k] !== exp_ord[k]) begin errors++; $display("FAIL rr_order %0d got %b exp %b", k, ord[k], exp_ord[k]); end
            checks++;
        end
        for (int k = 0; k < gaps.size(); k++) begin
            if (gaps[k] != GAP_CYC + 1) begin errors++; $display("FAIL rr_gap %0d got %0d exp %0d", k, gaps[k], GAP_CYC + 1); end
            checks++;
        end
    endtask

    task automatic run_timeout(input logic [N-1:0] r, input logic [N-1:0] exp_next);
        int hi, to_cnt;
        logic [N-1:0] nxt;
        do_reset();
        bus.req = r;
        hi = 0; to_cnt = 0; nxt = '0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL to_model cyc %0d got %h exp %h", c, obs, exp_vec());
            end
            checks++;
            if (bus.timeout) to_cnt++;
            if (to_cnt == 0 && bus.grant != '0) hi++;
            if (to_cnt > 0 && nxt == '0) nxt = bus.grant;
        end
        if (hi != MAX_HOLD) begin errors++; $display("FAIL to_hold got %0d exp %0d", hi, MAX_HOLD); end
        checks++;
        if (to_cnt != 1) begin errors++; $display("FAIL to_pulses got %0d exp 1", to_cnt); end
        checks++;
        if (nxt !== exp_next) begin errors++; $display("FAIL to_next got %b exp %b", nxt, exp_next); end
        checks++;
    endtask

    task automatic test_timeout();
        run_timeout(4'b0001, 4'b0001);
        run_timeout(4'b0011, 4'b0010);
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req = 4'b0010;
        tick();
        if (bus.grant !== 4'b0010) begin errors++; $display("FAIL mid_pre got %b exp 0010", bus.grant); end
        checks++;
        #2 areset = 1'b1;
        #1;
        if (bus.grant !== '0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mid_async got grant %b busy %b exp 0 0", bus.grant, bus.busy);
        end
        checks++;
        @(negedge clk);
        areset = 1'b0;
        model_reset();
        bus.req = 4'b0011;
        tick();
        if (bus.grant !== 4'b0001 || obs !== exp_vec()) begin
            errors++; $display("FAIL mid_after got %h exp %h", obs, exp_vec());
        end
        checks++;
    endtask

    task automatic test_tie();
        do_reset();
        bus.req = 4'b0001;
        repeat (MAX_HOLD) tick();
        if (bus.grant !== 4'b0001) begin errors++; $display("FAIL tie_held got %b exp 0001", bus.grant); end
        checks++;
        bus.req = '0;
        tick();
        if (bus.timeout !== 1'b0 || bus.grant !== '0 || obs !== exp_vec()) begin
            errors++; $display("FAIL tie_release got %h exp %h", obs, exp_vec());
        end
        checks++;
        bus.req = 4'b0010;
        tick();
        bus.req = '0;
        for (int c = 0; c < 5; c++) begin
            if (bus.grant !== '0 || obs !== exp_vec()) begin
                errors++; $display("FAIL gap_pulse cyc %0d got %h exp %h", c, obs, exp_vec());
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        bus.req = '0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom);
            tick();
            if (obs !== exp_vec() || $countones(bus.grant) > 1) begin
                errors++; $display("FAIL rand cyc %0d req %b got %h exp %h", c, bus.req, obs, exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.req = '0;
        areset = 1'b1;
        model_reset();
        test_reset();
        test_voluntary();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_tie();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
